// File: rtl/switch_debouncer.sv
// Switch/joystick input conditioner: 2-flop synchroniser, E-clock-derived sample tick,
// per-channel stability counter, and registered rise/fall/changed strobes.
module switch_debouncer #(
  parameter int               WIDTH        = 16,
  parameter int               TICK_DIV     = 894,
  parameter int               STABLE_COUNT = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_e_n,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [PW-1:0]    pre_reg;
  logic             tick;
  logic [WIDTH-1:0] sw_reg;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic             changed_reg;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  // Synchroniser runs every clk; only the debounce sampling is gated by the E enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= RESET_VALUE;
      sync2_reg <= RESET_VALUE;
    end else begin
      sync1_reg <= sw_i;
      sync2_reg <= sync1_reg;
    end
  end

  // With TICK_DIV = 1 the prescaler sits at zero and tick degenerates to en_e_n.
  assign tick = en_e_n && (pre_reg == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg <= '0;
    end else if (tick) begin
      pre_reg <= '0;
    end else if (en_e_n) begin
      pre_reg <= pre_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CW-1:0] cnt_reg;
      logic          differ;
      logic          at_last;

      assign differ      = sync2_reg[gi] ^ sw_reg[gi];
      assign at_last     = (cnt_reg == CNT_LAST);
      assign accept[gi]  = tick && differ && at_last;

      // Counter clears on agreement or on acceptance, so it never passes STABLE_COUNT-1.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (tick) begin
          if (!differ || at_last) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign rise_next = accept & sync2_reg;
  assign fall_next = accept & ~sync2_reg;

  // Strobes are registered alongside sw_reg so they coincide with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_reg      <= RESET_VALUE;
      rise_reg    <= '0;
      fall_reg    <= '0;
      changed_reg <= 1'b0;
    end else begin
      sw_reg      <= (sw_reg & ~accept) | (sync2_reg & accept);
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      changed_reg <= |accept;
    end
  end

  assign sw_o      = sw_reg;
  assign rise_o    = rise_reg;
  assign fall_o    = fall_reg;
  assign changed_o = changed_reg;

endmodule
